// File: rtl/i2s_pcm_tx.sv
// I2S transmitter: buffers one mono PCM sample and sends it on both slots, bclk/lrclk derived from clk.
// Define I2S_PCM_TX_HOLD_LAST_EN to repeat the last sample on underrun instead of sending silence.
module i2s_pcm_tx #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pcm_in,
  input  logic              pcm_valid,
  output logic              pcm_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam int unsigned DivW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BitW  = $clog2(2 * DATA_W);
  localparam int unsigned SlotW = $clog2(DATA_W);

  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(2 * DATA_W - 1);

  logic [DivW-1:0]   div_cnt;
  logic [BitW-1:0]   bit_cnt;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic [DATA_W-1:0] frame;

  logic              fe;
  logic              load;
  logic              accept;
  logic [BitW-1:0]   bit_nxt;
  logic [BitW-1:0]   slot_pos;
  logic [BitW-1:0]   bit_idx;
  logic [DATA_W-1:0] frame_nxt;
  logic              hold_full_nxt;
  logic              sdata_nxt;
  logic              lrclk_nxt;

  always_comb begin
    fe      = (div_cnt == DivLast) && bclk;
    load    = fe && (bit_cnt == BitLast);
    accept  = pcm_valid && pcm_ready;
    bit_nxt = (bit_cnt == BitLast) ? '0 : bit_cnt + BitW'(1);

    // Load sees the pre-accept holding state; a same-cycle accept waits for the next frame.
    frame_nxt     = frame;
    hold_full_nxt = hold_full;
    if (load) begin
      if (hold_full) begin
        frame_nxt     = hold_data;
        hold_full_nxt = 1'b0;
      end else begin
`ifdef I2S_PCM_TX_HOLD_LAST_EN
        frame_nxt = frame;
`else
        frame_nxt = '0;
`endif
      end
    end
    if (accept) begin
      hold_full_nxt = 1'b1;
    end

    // Both slots carry the same sample MSB first.
    slot_pos  = (bit_nxt < BitW'(DATA_W)) ? bit_nxt : bit_nxt - BitW'(DATA_W);
    bit_idx   = BitW'(DATA_W - 1) - slot_pos;
    sdata_nxt = frame_nxt[bit_idx[SlotW-1:0]];

    // Word select leads each slot's MSB by one bit.
    lrclk_nxt = (bit_nxt >= BitW'(DATA_W - 1)) && (bit_nxt <= BitW'(2 * DATA_W - 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= BitLast;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      pcm_ready <= 1'b1;
      hold_data <= '0;
      hold_full <= 1'b0;
      frame     <= '0;
    end else begin
      div_cnt <= (div_cnt == DivLast) ? '0 : div_cnt + DivW'(1);
      if (div_cnt == DivLast) begin
        bclk <= ~bclk;
      end
      if (fe) begin
        bit_cnt <= bit_nxt;
        lrclk   <= lrclk_nxt;
        sdata   <= sdata_nxt;
        frame   <= frame_nxt;
      end
      underrun <= load && !hold_full;
      if (accept) begin
        hold_data <= pcm_in;
      end
      hold_full <= hold_full_nxt;
      pcm_ready <= !hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_pcm_tx.sv
// Self-checking bench for i2s_pcm_tx: per-cycle reference model, table of frames, directed corners.
module tb_i2s_pcm_tx;

  localparam int D = 2;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  pcm_in;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;

  i2s_pcm_tx #(
    .DATA_W  (W),
    .BCLK_DIV(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pcm_in   (pcm_in),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timing derived arithmetically from clocks since reset release.
  bit          chk_en = 1'b0;
  int          n = 0;
  int          m_b = 2 * W - 1;
  bit          m_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_frame = '0;
  bit          m_und = 1'b0;
  bit          m_acc = 1'b0;
  int          m_loads = 0;
  int          m_words = 0;
  logic [31:0] cap = '0;
  logic [31:0] last_word = '0;

  always @(posedge clk) begin
    bit acc;
    bit m_lr;
    bit m_sd;
    bit m_bclk;
    int idx;
    if (reset === 1'b1) begin
      n = 0; m_full = 0; m_frame = '0; m_b = 2 * W - 1; m_und = 0; m_acc = 0; chk_en = 1;
    end else if (chk_en) begin
      acc = pcm_valid && !m_full;
      n++;
      m_und = 0;
      if (n % (2 * D) == 0) begin
        m_b = (2 * W - 1 + n / (2 * D)) % (2 * W);
        if (m_b == 0) begin
          m_loads++;
          if (m_full) begin
            m_frame = m_hold;
            m_full  = 0;
          end else begin
            m_und = 1;
`ifndef I2S_PCM_TX_HOLD_LAST_EN
            m_frame = '0;
`endif
          end
        end
      end
      if (acc) begin
        m_hold = pcm_in;
        m_full = 1;
      end
      m_acc = acc;
    end
    #1;
    if (chk_en) begin
      m_bclk = ((n / D) % 2) == 1;
      m_lr   = (m_b >= W - 1) && (m_b <= 2 * W - 2);
      idx    = (m_b < W) ? (W - 1 - m_b) : (2 * W - 1 - m_b);
      m_sd   = m_frame[idx];
      check("cycle{bclk,lrclk,sdata,underrun,ready}", {27'd0, bclk, lrclk, sdata, underrun, pcm_ready},
            {27'd0, m_bclk, m_lr, m_sd, m_und, !m_full});
      if (n > 0 && (n % (2 * D) == D)) begin
        cap = {cap[30:0], sdata};
        if (m_b == 2 * W - 1) begin
          last_word = cap;
          m_words++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] s, output int loads_at_accept);
    int k = 0;
    @(negedge clk);
    while (!pcm_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("send_timeout", 1, 0);
    pcm_in    = s;
    pcm_valid = 1'b1;
    @(posedge clk);
    #2;
    loads_at_accept = m_loads;
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic wait_load(input int l0);
    int k = 0;
    while (m_loads <= l0 && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 400) check("load_timeout", 1, 0);
  endtask

  task automatic wait_word();
    int w0 = m_words;
    int k  = 0;
    while (m_words <= w0 && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 400) check("word_timeout", 1, 0);
  endtask

  task automatic expect_frame(input string name, input int l0, input logic [31:0] exp);
    wait_load(l0);
    wait_word();
    check(name, last_word, exp);
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic [31:0]  word;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int l0;
    int l1;
    int k;
    int und_cnt;
    int low_cnt;
    logic [31:0] starve_word;

    vecs[0] = '{s: 16'hA5C3, word: 32'hA5C3_A5C3};
    vecs[1] = '{s: 16'h8000, word: 32'h8000_8000};
    vecs[2] = '{s: 16'h0001, word: 32'h0001_0001};
    vecs[3] = '{s: 16'h00FF, word: 32'h00FF_00FF};

    reset = 1'b1; pcm_valid = 1'b0; pcm_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {28'd0, bclk, lrclk, sdata, underrun}, 32'd0);
    check("reset_ready", {31'd0, pcm_ready}, 32'd1);
    reset = 1'b0;

    k = 0;
    while (k < 10) begin
      @(posedge clk);
      #2;
      k++;
      if (bclk) break;
    end
    check("first_bclk_rise_clk", k, 2);

    // Table: each sample becomes one frame carrying it on both slots.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].s, l0);
      expect_frame($sformatf("frame_%0d", i), l0, vecs[i].word);
    end

    // Starvation: one underrun pulse per frame.
    und_cnt = 0;
    for (int c = 0; c < 3 * 4 * D * W; c++) begin
      @(posedge clk);
      #2;
      if (underrun) und_cnt++;
    end
    check("starve_underrun_count", und_cnt, 3);
`ifdef I2S_PCM_TX_HOLD_LAST_EN
    starve_word = 32'h00FF_00FF;
`else
    starve_word = 32'h0;
`endif
    check("starve_frame", last_word, starve_word);

    // Back-pressure: second sample waits for the first one's frame load.
    @(negedge clk);
    pcm_in = 16'h1234; pcm_valid = 1'b1;
    k = 0;
    do begin @(posedge clk); #2; k++; end while (!m_acc && k < 400);
    l0 = m_loads;
    @(negedge clk);
    pcm_in = 16'h8001;
    k = 0; low_cnt = 0;
    do begin
      if (!pcm_ready) low_cnt++;
      @(posedge clk); #2; k++;
    end while (!m_acc && k < 400);
    check("bp_ready_low", {31'd0, low_cnt > 0}, 32'd1);
    check("bp_accept_after_load", {31'd0, m_loads > l0}, 32'd1);
    l1 = m_loads;
    @(negedge clk);
    pcm_valid = 1'b0;
    wait_word();
    check("bp_frame_1234", last_word, 32'h1234_1234);
    expect_frame("bp_frame_8001", l1, 32'h8001_8001);

    // Reset at bit 7 of a 0x7FFF frame, with another sample held.
    send(16'h7FFF, l0);
    wait_load(l0);
    send(16'h1111, l0);
    k = 0;
    do begin @(negedge clk); k++; end while (m_b != 7 && k < 400);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("midreset_outs", {28'd0, bclk, lrclk, sdata, underrun}, 32'd0);
    check("midreset_ready", {31'd0, pcm_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_load(m_loads);
    check("post_reset_underrun", {31'd0, underrun}, 32'd1);
    wait_word();
    check("post_reset_frame", last_word, 32'h0);

    // Random traffic with occasional resets, checked cycle by cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom % 1500) == 0;
      if (!pcm_valid || m_acc) begin
        pcm_valid = ($urandom % 3) == 0;
        pcm_in    = W'($urandom);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    pcm_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
